serial_tx: RTL
==============

Name: serial_tx

Overview:
- Byte-wide serializer (UART-style frame transmitter) for the common arch test suite.
- Accepts a parallel word over a valid/ready handshake and shifts it out on a single line: start bit, DATA_W data bits LSB-first, then stop bit(s).
- It is the transmit-side counterpart of the capture flops: it exercises sync-reset, clock-enable and shift-register inference in every arch flow.

Parameters:
- DATA_W, 8, data bits per frame (legal range 5..9).
- CLKS_PER_BIT, 4, clock cycles each line bit is held (legal range ≥ 2).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-low reset.
- d  input  DATA_W  word to transmit.
- valid  input  1  d is valid this cycle.
- ready  output  1  block accepts d this cycle.
- tx  output  1  serial line, idle-high.
- busy  output  1  frame in progress.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low, ports clk and clr. All flops update on posedge clk only; clr is sampled on posedge clk; no async paths.
- Reset (clr==0 at a posedge) sets:
  - state=IDLE, tx=1, busy=0, ready=1;
  - bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts the frame immediately. tx is 1 on the cycle after the reset edge, and the partial frame is never resumed.
- Handshake: a transfer occurs on a posedge with valid&ready.
  - ready = (state==IDLE), registered.
  - ready and busy are mutually exclusive.
  - d is captured into the shift register only on a transfer. d and valid are ignored at all other times, including valid held high while busy.
- States:
  - IDLE: tx=1. On transfer go to START; busy=1 and ready=0 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0], each bit held CLKS_PER_BIT cycles. Shift right at the end of each bit. After DATA_W bits go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE; ready=1 and busy=0 from that cycle.
- Latency: tx falls on the cycle after the transfer edge. Frame length is (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back transfers: valid may be asserted in the first IDLE cycle after STOP. The minimum inter-frame gap is 1 IDLE cycle, in which tx=1.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary;
  - width is clog2(CLKS_PER_BIT);
  - reset to 0 on every state change.
- Bit counter:
  - width is clog2(DATA_W+1);
  - counts 0..DATA_W-1 in DATA and 0..STOP_BITS-1 in STOP;
  - must not overflow for DATA_W=9.
- tx is driven from a flop (glitch-free), never from combinational state decode.
- Initial values: initial block sets tx=1, busy=0, ready=1 so post-config state matches reset.

Decomposition:
- Shared include file (serial_defs.vh) holds:
  - localparams for the state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the idle line level, shared with any future serial receiver test.
- One natural sub-module, serial_baud_tick, holds the baud counter:
  - parameter CLKS_PER_BIT;
  - ports clk, clr, restart, tick;
  - tick is asserted in the last cycle of each bit period.

Test Plan:
- Reset: hold clr=0 for 3 cycles with valid=1, d=8'hFF -> tx=1, ready=1, busy=0 throughout; no frame starts until clr=1.
- Single frame: defaults, d=8'hA5, one-cycle valid -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 4 cycles. busy high for exactly 40 cycles; ready returns high at cycle 41.
- Back-to-back: valid held high with d=8'h00 then 8'hFF -> second start bit begins exactly 1 idle cycle after the first stop bit. Each word is captured once; no extra frame is sent while valid stays high during busy.
- Ignore while busy: change d to 8'h3C mid-frame of 8'h81 -> 8'h81 is transmitted unaltered.
- Reset mid-frame: assert clr=0 during data bit 3 of 8'h55 -> next cycle tx=1, state IDLE, ready=1. A new transfer of 8'h0F then produces a clean full frame.
- Parameter corners: DATA_W=9, CLKS_PER_BIT=2, STOP_BITS=2, d=9'h1FF -> frame of 12 bits = 24 cycles; tx low only in the 2 start cycles.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and line levels.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Level the line rests at between frames; a future receiver shares it.
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick marks the last cycle of each bit.
module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style frame transmitter: start bit, DATA_W bits LSB-first, STOP_BITS stop bits.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e            state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tick, restart;

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

    // Counter is held at zero while idle so every frame starts on a clean bit period.
    assign restart = (state_d != state_q) || (state_q == IDLE);

    serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: if (valid && ready_q) begin
                state_d = START;
                shift_d = d;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                bit_d   = '0;
            end
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_q == LAST_DATA) begin
                    state_d = STOP;
                    tx_d    = LINE_IDLE;
                    bit_d   = '0;
                end else begin
                    tx_d  = shift_d[0];
                    bit_d = bit_q + 1'b1;
                end
            end
            STOP: if (tick) begin
                if (bit_q == LAST_STOP) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

endmodule
